// File: rtl/frame_packer_pkg.sv
// Shared types and constants for the frame packer slice.
// FRAME_CHECKSUM_EN adds a per-frame XOR checksum field to FIFO entries.
package frame_packer_pkg;

    localparam int FRAME_CNT_W = 16;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_BEATS   = 4;
    localparam int DEF_DEPTH   = 2;

    typedef logic [DEF_BEATS-1:0][DEF_WIDTH-1:0] frame_t;

    typedef struct packed {
`ifdef FRAME_CHECKSUM_EN
        logic [DEF_WIDTH-1:0] checksum;
`endif
        frame_t               frame;
    } fifo_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/frame_fifo.sv
// DEPTH-entry in-order frame FIFO with combinational head output.
// Head reads as all zeros while empty.
module frame_fifo
    import frame_packer_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type T_ENTRY = fifo_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_push,
    input  T_ENTRY i_wdata,
    input  logic   i_pop,
    output T_ENTRY o_rdata,
    output logic   o_full,
    output logic   o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    T_ENTRY             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO may still accept when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; the empty flag masks stale entries on the head output.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/frame_packer.sv
// Packs BEATS valid samples into one frame and queues frames behind a valid/ready port.
// Define FRAME_CHECKSUM_EN to add o_checksum (XOR of the head frame's samples).
module frame_packer
    import frame_packer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BEATS = DEF_BEATS,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_valid,
    input  logic                   i_flush,
    output logic [WIDTH*BEATS-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_overflow,
`ifdef FRAME_CHECKSUM_EN
    output logic [WIDTH-1:0]       o_checksum,
`endif
    output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

    localparam int IDX_W = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    typedef logic [BEATS-1:0][WIDTH-1:0] frame_word_t;
    typedef struct packed {
`ifdef FRAME_CHECKSUM_EN
        logic [WIDTH-1:0] checksum;
`endif
        frame_word_t      frame;
    } entry_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [IDX_W-1:0]          r_beat_idx;
    logic [BEATS-2:0][WIDTH-1:0] r_lanes;
    logic                      r_overflow;
    logic [FRAME_CNT_W-1:0]    r_frame_cnt;

    logic                      w_accept;
    logic                      w_last;
    logic                      w_idx_clr;
    logic                      w_pop;
    logic                      w_push_ok;
    logic                      w_full;
    logic                      w_empty;
    entry_t                    w_entry;
    entry_t                    w_head;

    assign w_accept = i_valid && !i_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)            w_state_next = ST_FILL;
            ST_FILL: if (i_flush || w_last)   w_state_next = ST_IDLE;
            default:                          w_state_next = ST_IDLE;
        endcase
    end

    // Beat index is always 0 in IDLE, so the last beat can only arrive in FILL.
    always_comb begin
        w_last    = 1'b0;
        w_idx_clr = 1'b0;
        case (r_state)
            ST_IDLE: w_idx_clr = i_flush;
            ST_FILL: begin
                w_last    = w_accept && (r_beat_idx == LAST_IDX);
                w_idx_clr = i_flush || w_last;
            end
            default: w_idx_clr = 1'b1;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values; comb blocks use =.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat_idx <= '0;
            r_lanes    <= '0;
        end else begin
            if (w_idx_clr)     r_beat_idx <= '0;
            else if (w_accept) r_beat_idx <= r_beat_idx + IDX_W'(1);
            for (int k = 0; k < BEATS - 1; k++) begin
                if (w_accept && (r_beat_idx == IDX_W'(k))) r_lanes[k] <= i_data;
            end
        end
    end

    always_comb begin
        w_entry = '0;
        for (int k = 0; k < BEATS - 1; k++) w_entry.frame[k] = r_lanes[k];
        w_entry.frame[BEATS-1] = i_data;
`ifdef FRAME_CHECKSUM_EN
        w_entry.checksum = i_data;
        for (int k = 0; k < BEATS - 1; k++) w_entry.checksum = w_entry.checksum ^ r_lanes[k];
`endif
    end

    assign w_pop     = !w_empty && i_ready;
    assign w_push_ok = !w_full || w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_last) begin
            if (w_push_ok) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            else           r_overflow  <= 1'b1;
        end
    end

    frame_fifo #(
        .DEPTH   (DEPTH),
        .T_ENTRY (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_last && w_push_ok),
        .i_wdata (w_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_valid     = !w_empty;
    assign o_data      = w_head.frame;
    assign o_overflow  = r_overflow;
    assign o_frame_cnt = r_frame_cnt;
`ifdef FRAME_CHECKSUM_EN
    assign o_checksum  = w_head.checksum;
`endif

endmodule
